bandit_environment: RTL and testbench
=====================================

Name: bandit_environment

Overview:
- Hardware stand-in for the stochastic environment that `bandit` plays against.
- Consumes one action (arm index) from the agent and returns one Bernoulli reward. The reward is drawn by comparing an internal 16-bit LFSR sample against a per-arm probability threshold.
- Connects port-for-port to `bandit`: its `action_*` stream is our input and its `reward_*` stream is our output. Used for closed-loop simulation and FPGA self-test.

Parameters:
- ARMS, 256, number of arms; table depth; must be ≤ 2^ACTION_WIDTH.
- ACTION_WIDTH, 8, action_data width.
- REWARD_WIDTH, 16, reward_data width.
- REWARD_HIT, 16'h7FFF, reward value on success.
- REWARD_MISS, 16'h0000, reward value on failure.
- LFSR_SEED, 16'hACE1, LFSR value after reset; 0 is replaced by 16'h0001.
- PROB_FILE, "", hex file loaded with $readmemh into the probability table at time 0; empty string means the table is left uninitialised.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- action_valid  input  1  agent presents an arm index.
- action_data  input  ACTION_WIDTH  arm index.
- action_ready  output  1  environment can accept an action.
- reward_valid  output  1  reward_data is valid.
- reward_data  output  REWARD_WIDTH  REWARD_HIT or REWARD_MISS.
- reward_ready  input  1  agent accepts the reward.

Behaviour:
- Reset (asynchronous assert, reset=0):
  - state=IDLE, action_ready=0 while reset is asserted, reward_valid=0, reward_data=REWARD_MISS, lfsr=LFSR_SEED (or 1 if the seed is 0).
  - The probability table is not cleared.
  - Reset mid-transaction drops any pending reward; no handshake completes.
- Handshakes: AXI-stream style; a transfer occurs on a rising edge with valid&&ready both high.
  - reward_valid, once high, stays high and reward_data stays stable until the transfer.
  - Exactly one outstanding transaction at a time.
- State machine:
  - IDLE:
    - action_ready=1.
    - On action transfer: latch the arm, issue a synchronous table read at the arm address, advance the LFSR one step, go to LOOKUP.
  - LOOKUP:
    - action_ready=0.
    - Table data is available; compute hit = (arm < ARMS) && (lfsr ≤ prob[arm]), unsigned 16-bit compare using the post-advance LFSR value.
    - Register reward_data = hit ? REWARD_HIT : REWARD_MISS, set reward_valid=1, go to RESPOND.
  - RESPOND:
    - action_ready=0, reward_valid=1.
    - On reward transfer: reward_valid=0, go to IDLE.
  - Latency: action accepted at edge N; reward_valid high after edge N+2; earliest next action accepted at edge N+4 (one IDLE cycle required).
  - action_valid asserted outside IDLE is ignored and held off by action_ready=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts only on action accept.
  - Value never 0 (range 1..FFFF), hence prob=0 gives probability 0 and prob=FFFF gives probability 1; in general P(hit) = prob/65535.
- Boundary: an arm index ≥ ARMS returns REWARD_MISS, with no table access side effects.

Optional Feature:
- Macro: BANDIT_ENVIRONMENT_CONFIG_EN.
- Defined: adds ports config_valid(in,1), config_addr(in,ACTION_WIDTH), config_data(in,16), config_ready(out,1; constant 1 after reset, 0 while reset is asserted).
  - Each transfer writes prob[config_addr] = config_data; addresses ≥ ARMS are dropped.
  - Writes are accepted in any state. A write to the arm being read in the same cycle returns the old value (read-first); the new value applies to later actions.
- Undefined: no config ports; the table is fixed by PROB_FILE.

Test Plan:
- Reset state: hold reset=0 for 3 cycles then release → action_ready=1 on the first edge after release; reward_valid=0 and reward_data=0000 throughout reset.
- Never-pays arm: prob[0]=0000, present action 0 ten times with reward_ready=1 → ten rewards, all 0000; each reward_valid rises exactly 2 edges after its action accept.
- Always-pays arm and out-of-range arm: prob[1]=FFFF, ARMS=4 → action 1 gives 7FFF every time; action 9 gives 0000.
- Backpressure and LFSR determinism:
  - prob[2]=8000; hold reward_ready=0 for 5 cycles after reward_valid → reward_valid and reward_data stable and action_ready=0 throughout.
  - 1000 actions → hit count equals a reference model of the same LFSR sequence from seed ACE1 (approx. 500).
- Reset mid-transaction: assert reset while in RESPOND → reward_valid drops immediately (asynchronously). After release, the next action's LFSR value equals the first post-seed step, i.e. the sequence restarts.
- With BANDIT_ENVIRONMENT_CONFIG_EN: write prob[3]=FFFF, then action 3 → 7FFF. Write prob[3]=0000 in the same cycle as action 3 is accepted → that reward uses FFFF (7FFF); the following action 3 → 0000.

Source files
------------

// File: rtl/bandit_environment.sv
// bandit_environment: stochastic reward source that the bandit agent plays against.
// The agent sends one arm index. The block answers with one Bernoulli reward. That reward
// is drawn by comparing a 16-bit Fibonacci LFSR sample with the arm's probability threshold.
// Optional feature macro: BANDIT_ENVIRONMENT_CONFIG_EN. It adds a write port that lets the
// probability table be changed at run time.
module bandit_environment #(
    parameter int unsigned               ARMS         = 256,
    parameter int unsigned               ACTION_WIDTH = 8,
    parameter int unsigned               REWARD_WIDTH = 16,
    parameter logic [REWARD_WIDTH-1:0]   REWARD_HIT   = 16'h7FFF,
    parameter logic [REWARD_WIDTH-1:0]   REWARD_MISS  = 16'h0000,
    parameter logic [15:0]               LFSR_SEED    = 16'hACE1,
    parameter string                     PROB_FILE    = ""
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    action_valid,
    input  logic [ACTION_WIDTH-1:0] action_data,
    output logic                    action_ready,
    output logic                    reward_valid,
    output logic [REWARD_WIDTH-1:0] reward_data,
    input  logic                    reward_ready
`ifdef BANDIT_ENVIRONMENT_CONFIG_EN
    ,
    input  logic                    config_valid,
    input  logic [ACTION_WIDTH-1:0] config_addr,
    input  logic [15:0]             config_data,
    output logic                    config_ready
`endif
);

    localparam int unsigned ADDR_W = (ARMS > 1) ? $clog2(ARMS) : 1;
    localparam logic [ACTION_WIDTH:0] ARMS_LIMIT = (ACTION_WIDTH+1)'(ARMS);
    // A zero seed would lock the LFSR at zero forever.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESPOND} state_t;

    // Right-shifting Fibonacci form with taps 16,14,13,11. It is maximal length.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    logic [15:0] prob_mem [ARMS];
    logic [15:0] prob_rd_q;

    state_t                  state_q, state_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic                    arm_ok_q, arm_ok_d;
    logic                    hit_q, hit_d;
    logic                    cmp_done_q, cmp_done_d;
    logic                    action_ready_q, action_ready_d;
    logic                    reward_valid_q, reward_valid_d;
    logic [REWARD_WIDTH-1:0] reward_data_q, reward_data_d;

    logic              action_fire;
    logic              reward_fire;
    logic              act_in_range;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    assign action_fire  = action_valid && action_ready_q;
    assign reward_fire  = reward_valid_q && reward_ready;
    assign act_in_range = {1'b0, action_data} < ARMS_LIMIT;
    // Out-of-range arms never touch the table.
    assign rd_en        = action_fire && act_in_range;
    assign rd_addr      = action_data[ADDR_W-1:0];

    assign action_ready = action_ready_q;
    assign reward_valid = reward_valid_q;
    assign reward_data  = reward_data_q;

`ifdef BANDIT_ENVIRONMENT_CONFIG_EN
    logic config_ready_q;

    assign wr_en        = config_valid && config_ready_q && ({1'b0, config_addr} < ARMS_LIMIT);
    assign wr_addr      = config_addr[ADDR_W-1:0];
    assign wr_data      = config_data;
    assign config_ready = config_ready_q;

    // The config port is always ready once reset has been released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) config_ready_q <= 1'b0;
        else        config_ready_q <= 1'b1;
    end
`else
    assign wr_en   = 1'b0;
    assign wr_addr = '0;
    assign wr_data = '0;
`endif

    // Table port: synchronous read-first read on action accept, plus the optional write.
    // NOTE: the table is deliberately not reset. Its contents must survive reset, and a reset
    // would prevent block-RAM inference.
    always_ff @(posedge clock) begin
        if (wr_en) prob_mem[wr_addr] <= wr_data;
        if (rd_en) prob_rd_q <= prob_mem[rd_addr];
    end

    // Next-state logic. LOOKUP spends one cycle comparing and one cycle registering the reward.
    // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_q;
        arm_ok_d       = arm_ok_q;
        hit_d          = hit_q;
        cmp_done_d     = cmp_done_q;
        reward_valid_d = reward_valid_q;
        reward_data_d  = reward_data_q;
        case (state_q)
            S_IDLE: begin
                if (action_fire) begin
                    arm_ok_d   = act_in_range;
                    lfsr_d     = lfsr_step(lfsr_q);
                    cmp_done_d = 1'b0;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!cmp_done_q) begin
                    // lfsr_q already holds the post-advance sample.
                    hit_d      = arm_ok_q && (lfsr_q <= prob_rd_q);
                    cmp_done_d = 1'b1;
                end else begin
                    reward_data_d  = hit_q ? REWARD_HIT : REWARD_MISS;
                    reward_valid_d = 1'b1;
                    state_d        = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (reward_fire) begin
                    reward_valid_d = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        action_ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs. Reset drops any pending reward at once.
    // NOTE: non-blocking assignments let every flop sample the pre-edge values together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            lfsr_q         <= SEED;
            arm_ok_q       <= 1'b0;
            hit_q          <= 1'b0;
            cmp_done_q     <= 1'b0;
            action_ready_q <= 1'b0;
            reward_valid_q <= 1'b0;
            reward_data_q  <= REWARD_MISS;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            arm_ok_q       <= arm_ok_d;
            hit_q          <= hit_d;
            cmp_done_q     <= cmp_done_d;
            action_ready_q <= action_ready_d;
            reward_valid_q <= reward_valid_d;
            reward_data_q  <= reward_data_d;
        end
    end

endmodule

// File: tb/tb_bandit_environment.sv
// tb_bandit_environment: table-driven vectors and a reward scoreboard for bandit_environment.
// The DUT is built with ARMS=4. BANDIT_ENVIRONMENT_CONFIG_EN selects how the table is loaded
// and enables the run-time write checks.
module tb_bandit_environment;

    localparam int NARMS = 4;

    logic        clock;
    logic        reset;
    logic        action_valid;
    logic [7:0]  action_data;
    logic        action_ready;
    logic        reward_valid;
    logic [15:0] reward_data;
    logic        reward_ready;
`ifdef BANDIT_ENVIRONMENT_CONFIG_EN
    logic        config_valid;
    logic [7:0]  config_addr;
    logic [15:0] config_data;
    logic        config_ready;
    bit          cfg_pending;
    logic [7:0]  cfg_addr_v;
    logic [15:0] cfg_data_v;
`endif

    bandit_environment #(.ARMS(NARMS)) dut (
        .clock        (clock),
        .reset        (reset),
        .action_valid (action_valid),
        .action_data  (action_data),
        .action_ready (action_ready),
        .reward_valid (reward_valid),
        .reward_data  (reward_data),
        .reward_ready (reward_ready)
`ifdef BANDIT_ENVIRONMENT_CONFIG_EN
        ,
        .config_valid (config_valid),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_ready (config_ready)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] prob_m [NARMS];
    logic [15:0] lfsr_m;

    typedef struct {
        logic [7:0]  arm;
        logic [15:0] exp;
        bit          known;
        int          hold;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference LFSR written in the shift/mask form of the textbook C routine.
    function automatic logic [15:0] model_step(input logic [15:0] l);
        logic [15:0] b;
        b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
        return (l >> 1) | (b << 15);
    endfunction

    // Call this task only at a negedge.
    task automatic set_prob(input logic [7:0] addr, input logic [15:0] val);
`ifdef BANDIT_ENVIRONMENT_CONFIG_EN
        config_valid = 1'b1;
        config_addr  = addr;
        config_data  = val;
        @(posedge clock);
        @(negedge clock);
        config_valid = 1'b0;
`else
        dut.prob_mem[addr[1:0]] = val;
`endif
        if (addr < NARMS) prob_m[addr[1:0]] = val;
    endtask

    // Present one action and wait for its accept edge. Push the model's expected reward.
    task automatic accept_action(input logic [7:0] arm);
        int          n;
        logic [15:0] e;
        action_valid = 1'b1;
        action_data  = arm;
`ifdef BANDIT_ENVIRONMENT_CONFIG_EN
        if (cfg_pending) begin
            config_valid = 1'b1;
            config_addr  = cfg_addr_v;
            config_data  = cfg_data_v;
        end
`endif
        n = 0;
        while (action_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("action_ready_timeout", 32'(n), 32'd0);
        @(posedge clock);
        lfsr_m = model_step(lfsr_m);
        e = ((arm < NARMS) && (lfsr_m <= prob_m[arm[1:0]])) ? 16'h7FFF : 16'h0000;
        exp_q.push_back(e);
`ifdef BANDIT_ENVIRONMENT_CONFIG_EN
        // The write lands after the read, so it only affects later actions.
        if (cfg_pending && cfg_addr_v < NARMS) prob_m[cfg_addr_v[1:0]] = cfg_data_v;
`endif
        @(negedge clock);
        action_valid = 1'b0;
`ifdef BANDIT_ENVIRONMENT_CONFIG_EN
        config_valid = 1'b0;
        cfg_pending  = 1'b0;
`endif
    endtask

    // Call this at the first negedge after the accept edge.
    task automatic collect_reward(input int hold, output logic [15:0] got);
        int          n;
        logic [15:0] held;
        logic [15:0] e;
        n = 0;
        while (reward_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("reward_latency_edges", 32'(n), 32'd2);
        held = reward_data;
        for (int i = 0; i < hold; i++) begin
            check("bp_reward_valid", 32'(reward_valid), 32'd1);
            check("bp_reward_data", 32'(reward_data), 32'(held));
            check("bp_action_ready", 32'(action_ready), 32'd0);
            @(negedge clock);
        end
        got = reward_data;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            e = 16'hxxxx;
        end else begin
            e = exp_q.pop_front();
        end
        check("reward_data", 32'(got), 32'(e));
        reward_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reward_ready = 1'b0;
        check("reward_valid_after_xfer", 32'(reward_valid), 32'd0);
    endtask

    task automatic send_action(input logic [7:0] arm, input int hold, output logic [15:0] got);
        accept_action(arm);
        collect_reward(hold, got);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] got;
        int          hits_dut;
        int          hits_model;
        int          n;

        reset        = 1'b0;
        action_valid = 1'b0;
        action_data  = 8'h00;
        reward_ready = 1'b0;
        lfsr_m       = 16'hACE1;
`ifdef BANDIT_ENVIRONMENT_CONFIG_EN
        config_valid = 1'b0;
        config_addr  = 8'h00;
        config_data  = 16'h0000;
        cfg_pending  = 1'b0;
        cfg_addr_v   = 8'h00;
        cfg_data_v   = 16'h0000;
`endif

        // Reset state: hold reset for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_reward_valid", 32'(reward_valid), 32'd0);
            check("rst_reward_data", 32'(reward_data), 32'h0000);
            check("rst_action_ready", 32'(action_ready), 32'd0);
        end
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_release", 32'(action_ready), 32'd1);

        set_prob(8'd0, 16'h0000);
        set_prob(8'd1, 16'hFFFF);
        set_prob(8'd2, 16'h8000);
        set_prob(8'd3, 16'h4000);

        for (int i = 0; i < 10; i++) vecs[i] = '{arm: 8'd0, exp: 16'h0000, known: 1'b1, hold: 0};
        vecs[10] = '{arm: 8'd1,   exp: 16'h7FFF, known: 1'b1, hold: 0};
        vecs[11] = '{arm: 8'd9,   exp: 16'h0000, known: 1'b1, hold: 0};
        vecs[12] = '{arm: 8'd1,   exp: 16'h7FFF, known: 1'b1, hold: 2};
        vecs[13] = '{arm: 8'd200, exp: 16'h0000, known: 1'b1, hold: 0};
        vecs[14] = '{arm: 8'd2,   exp: 16'h0000, known: 1'b0, hold: 5};
        vecs[15] = '{arm: 8'd1,   exp: 16'h7FFF, known: 1'b1, hold: 0};

        for (int i = 0; i < 16; i++) begin
            send_action(vecs[i].arm, vecs[i].hold, got);
            if (vecs[i].known) check($sformatf("vec%0d_arm%0d", i, vecs[i].arm), 32'(got), 32'(vecs[i].exp));
        end

        // Long run on the half-probability arm. The hit count must follow the model sequence.
        hits_dut   = 0;
        hits_model = 0;
        for (int i = 0; i < 1000; i++) begin
            accept_action(8'd2);
            if (exp_q[exp_q.size()-1] == 16'h7FFF) hits_model++;
            collect_reward(0, got);
            if (got == 16'h7FFF) hits_dut++;
        end
        check("hit_count_vs_model", 32'(hits_dut), 32'(hits_model));
        check("hit_count_plausible", 32'((hits_dut >= 400) && (hits_dut <= 600)), 32'd1);

`ifdef BANDIT_ENVIRONMENT_CONFIG_EN
        // Run-time table writes, including a write in the same cycle as the action accept.
        set_prob(8'd3, 16'hFFFF);
        send_action(8'd3, 0, got);
        check("cfg_write_hit", 32'(got), 32'h7FFF);
        cfg_pending = 1'b1;
        cfg_addr_v  = 8'd3;
        cfg_data_v  = 16'h0000;
        send_action(8'd3, 0, got);
        check("cfg_read_first", 32'(got), 32'h7FFF);
        send_action(8'd3, 0, got);
        check("cfg_write_applied", 32'(got), 32'h0000);
        check("config_ready_high", 32'(config_ready), 32'd1);
`endif

        // Reset while RESPOND holds a reward. The reward must vanish before the next edge.
        set_prob(8'd2, 16'h5670);
        accept_action(8'd1);
        n = 0;
        while (reward_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("mid_rst_reached_respond", 32'(reward_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid_async", 32'(reward_valid), 32'd0);
        check("mid_rst_data", 32'(reward_data), 32'h0000);
        check("mid_rst_ready", 32'(action_ready), 32'd0);
        exp_q.delete();
        lfsr_m = 16'hACE1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        // The first step after ACE1 is 5670, and a threshold of 5670 still hits.
        send_action(8'd2, 0, got);
        check("restart_lfsr_hit", 32'(got), 32'h7FFF);

        // Reset again while idle. A threshold one below the first step must miss.
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        lfsr_m = 16'hACE1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        set_prob(8'd2, 16'h566F);
        send_action(8'd2, 0, got);
        check("restart_lfsr_miss", 32'(got), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
